// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 slice: datapath width, OPMODE bit
// positions and the CARRYINSEL selector values.
package dsp48a1_pkg;

    localparam int WIDTH_P = 48;

    localparam int OPM_SUB = 7;
    localparam int OPM_CIN = 5;

    // Both selector strings are seven characters, so they compare at equal width.
    localparam CINSEL_OPMODE5 = "OPMODE5";
    localparam CINSEL_CARRYIN = "CARRYIN";

endpackage

// File: rtl/dsp_post_adder_if.sv
// Operand, control and result bundle of the post-adder stage, plus the
// carry-in register value exposed for observation.
interface dsp_post_adder_if
    import dsp48a1_pkg::*;
#(
    parameter int WIDTH = WIDTH_P
);
    // No valid/ready: every cycle's operands are consumed; CEP/CECARRYIN gate capture.
    logic             CEP;
    logic             CECARRYIN;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] z;
    logic             opmode7;
    logic             opmode5;
    logic             CARRYIN;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] PCOUT;
    logic             CARRYOUT;
    logic             CARRYOUTF;
    logic             cyi;

    modport master (
        output CEP, CECARRYIN, x, z, opmode7, opmode5, CARRYIN,
        input  P, PCOUT, CARRYOUT, CARRYOUTF, cyi
    );

    modport slave (
        input  CEP, CECARRYIN, x, z, opmode7, opmode5, CARRYIN,
        output P, PCOUT, CARRYOUT, CARRYOUTF, cyi
    );

endinterface

// File: rtl/reg_mux.sv
// Optional pipeline register with synchronous reset and clock enable;
// with REG = 0 the output follows the input combinationally.
module reg_mux #(
    parameter int WIDTH = 1,
    parameter int REG   = 1
) (
    input  logic             CLK,
    input  logic             RSTP,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (REG == 1) begin : g_reg
            logic [WIDTH-1:0] q_r;

            // Reset outranks the enable.
            always_ff @(posedge CLK) begin
                if (RSTP) begin
                    q_r <= '0;
                end else if (ce) begin
                    q_r <= d;
                end
            end

            assign q = q_r;
        end else begin : g_bypass
            logic unused_ctrl;

            assign unused_ctrl = &{1'b0, CLK, RSTP, ce};
            assign q           = d;
        end
    endgenerate

endmodule

// File: rtl/dsp_post_adder.sv
// Post-adder/subtracter and output register stage: P = Z +/- (X + CIN),
// with the carry or borrow registered alongside P as CARRYOUT.
module dsp_post_adder
    import dsp48a1_pkg::*;
#(
    parameter int WIDTH       = WIDTH_P,
    parameter int CARRYINREG  = 1,
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1,
    parameter     CARRYINSEL  = CINSEL_OPMODE5
) (
    input logic               CLK,
    input logic               RSTP,
    dsp_post_adder_if.slave   io
);

    logic             cin_src;
    logic             cin;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   r;
    logic             unused_cin_src;

    generate
        if (CARRYINSEL == CINSEL_CARRYIN) begin : g_cin_carryin
            assign cin_src = io.CARRYIN;
        end else if (CARRYINSEL == CINSEL_OPMODE5) begin : g_cin_opmode5
            assign cin_src = io.opmode5;
        end else begin : g_cin_bad
            $fatal(1, "dsp_post_adder: CARRYINSEL must be \"OPMODE5\" or \"CARRYIN\"");
            assign cin_src = 1'b0;
        end
    endgenerate

    // Only one of the two carry sources is used in any configuration.
    assign unused_cin_src = io.opmode5 ^ io.CARRYIN;

    reg_mux #(.WIDTH(1), .REG(CARRYINREG)) u_cyi (
        .CLK  (CLK),
        .RSTP (RSTP),
        .ce   (io.CECARRYIN),
        .d    (cin_src),
        .q    (cin)
    );

    // The addend is one bit wider than x so x = all-ones with cin = 1 cannot
    // wrap; the top bit of r is then the carry on add and the borrow on subtract.
    always_comb begin
        addend = {1'b0, io.x} + {{WIDTH{1'b0}}, cin};
        r      = '0;
        if (io.opmode7) begin
            r = {1'b0, io.z} - addend;
        end else begin
            r = {1'b0, io.z} + addend;
        end
    end

    reg_mux #(.WIDTH(WIDTH), .REG(PREG)) u_p (
        .CLK  (CLK),
        .RSTP (RSTP),
        .ce   (io.CEP),
        .d    (r[WIDTH-1:0]),
        .q    (io.P)
    );

    reg_mux #(.WIDTH(1), .REG(CARRYOUTREG)) u_carryout (
        .CLK  (CLK),
        .RSTP (RSTP),
        .ce   (io.CEP),
        .d    (r[WIDTH]),
        .q    (io.CARRYOUT)
    );

    assign io.PCOUT     = io.P;
    assign io.CARRYOUTF = io.CARRYOUT;
    assign io.cyi       = cin;

endmodule

// File: tb/tb_dsp_post_adder.sv
// Bench for dsp_post_adder: a registered OPMODE5 slice, a registered CARRYIN
// slice and a fully combinational slice, checked against an arithmetic model.
module tb_dsp_post_adder;

    localparam int W = 48;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] z;
        logic         sub;
        logic         o5;
        logic         cep;
        logic         ceci;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    dsp_post_adder_if #(.WIDTH(W)) a_if ();
    dsp_post_adder_if #(.WIDTH(W)) b_if ();
    dsp_post_adder_if #(.WIDTH(W)) c_if ();

    logic         a_fb   = 1'b0;
    logic [W-1:0] a_zdrv = '0;

    // External Z mux: either a driven operand or P fed back for accumulation.
    assign a_if.z = a_fb ? a_if.P : a_zdrv;

    assign c_if.x         = a_if.x;
    assign c_if.z         = a_if.z;
    assign c_if.opmode7   = a_if.opmode7;
    assign c_if.opmode5   = a_if.opmode5;
    assign c_if.CEP       = a_if.CEP;
    assign c_if.CECARRYIN = a_if.CECARRYIN;
    assign c_if.CARRYIN   = a_if.CARRYIN;

    dsp_post_adder #(.WIDTH(W)) dut_a (
        .CLK  (clk),
        .RSTP (rst),
        .io   (a_if.slave)
    );

    dsp_post_adder #(.WIDTH(W), .CARRYINSEL("CARRYIN")) dut_b (
        .CLK  (clk),
        .RSTP (rst),
        .io   (b_if.slave)
    );

    dsp_post_adder #(.WIDTH(W), .CARRYINREG(0), .PREG(0), .CARRYOUTREG(0)) dut_c (
        .CLK  (clk),
        .RSTP (rst),
        .io   (c_if.slave)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [W:0] model_r(input logic [W-1:0] x, input logic [W-1:0] z,
                                           input logic sub, input logic cin);
        longint unsigned xl, zl, s;
        xl = 64'(x);
        zl = 64'(z);
        if (sub) s = zl - (xl + 64'(cin));
        else     s = zl + xl + 64'(cin);
        return s[W:0];
    endfunction

    logic [W+1:0] exp_q_a[$];
    logic [W+1:0] exp_q_b[$];

    logic         a_valid = 1'b0, b_valid = 1'b0;
    logic [W-1:0] a_p_m = '0, b_p_m = '0;
    logic         a_co_m = 1'b0, b_co_m = 1'b0;
    logic         a_cyi_m = 1'b0, b_cyi_m = 1'b0;

    always @(posedge clk) begin : model
        logic [W:0]   ra, rb;
        logic [W-1:0] pa, pb;
        logic         coa, cob, cya, cyb;

        ra  = model_r(a_if.x, a_if.z, a_if.opmode7, a_cyi_m);
        cya = rst ? 1'b0 : (a_if.CECARRYIN ? a_if.opmode5 : a_cyi_m);
        if (rst)           {coa, pa} = '0;
        else if (a_if.CEP) {coa, pa} = ra;
        else               {coa, pa} = {a_co_m, a_p_m};

        rb  = model_r(b_if.x, b_if.z, b_if.opmode7, b_cyi_m);
        cyb = rst ? 1'b0 : (b_if.CECARRYIN ? b_if.CARRYIN : b_cyi_m);
        if (rst)           {cob, pb} = '0;
        else if (b_if.CEP) {cob, pb} = rb;
        else               {cob, pb} = {b_co_m, b_p_m};

        a_cyi_m <= cya;  a_co_m <= coa;  a_p_m <= pa;
        b_cyi_m <= cyb;  b_co_m <= cob;  b_p_m <= pb;
        a_valid <= a_valid | rst;
        b_valid <= b_valid | rst;
        if (a_valid || rst) exp_q_a.push_back({cya, coa, pa});
        if (b_valid || rst) exp_q_b.push_back({cyb, cob, pb});
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [W+1:0] e;
        logic [W:0]   rc;
        if (exp_q_a.size() > 0) begin
            e = exp_q_a.pop_front();
            check("a_p",         64'(a_if.P),         64'(e[W-1:0]));
            check("a_pcout",     64'(a_if.PCOUT),     64'(e[W-1:0]));
            check("a_carryout",  64'(a_if.CARRYOUT),  64'(e[W]));
            check("a_carryoutf", 64'(a_if.CARRYOUTF), 64'(e[W]));
            check("a_cyi",       64'(a_if.cyi),       64'(e[W+1]));
        end
        if (exp_q_b.size() > 0) begin
            e = exp_q_b.pop_front();
            check("b_p",        64'(b_if.P),        64'(e[W-1:0]));
            check("b_carryout", 64'(b_if.CARRYOUT), 64'(e[W]));
            check("b_cyi",      64'(b_if.cyi),      64'(e[W+1]));
        end
        rc = model_r(c_if.x, c_if.z, c_if.opmode7, c_if.opmode5);
        check("c_p",         64'(c_if.P),         64'(rc[W-1:0]));
        check("c_pcout",     64'(c_if.PCOUT),     64'(rc[W-1:0]));
        check("c_carryout",  64'(c_if.CARRYOUT),  64'(rc[W]));
        check("c_carryoutf", 64'(c_if.CARRYOUTF), 64'(rc[W]));
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Carry is loaded into CYI one edge ahead of the operands it applies to.
    task automatic op_a(input logic [W-1:0] x, input logic [W-1:0] z,
                        input logic sub, input logic cin);
        a_if.opmode5 = cin;
        tick();
        a_if.x       = x;
        a_zdrv       = z;
        a_if.opmode7 = sub;
        a_if.opmode5 = 1'b0;
        tick();
    endtask

    task automatic pulse_b(input logic ceci_during_pulse);
        b_if.x = '0; b_if.z = '0; b_if.CARRYIN = 1'b0; b_if.CECARRYIN = 1'b1;
        tick();
        b_if.CARRYIN = 1'b1; b_if.CECARRYIN = ceci_during_pulse;
        tick();
        b_if.CARRYIN = 1'b0; b_if.CECARRYIN = 1'b1;
        b_if.x = 48'h1; b_if.z = 48'h1;
        tick();
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{x: 48'h123456789ABC, z: 48'h0F0F0F0F0F0F, sub: 1'b0, o5: 1'b1, cep: 1'b1, ceci: 1'b1};
        tbl[1] = '{x: 48'h000000000001, z: 48'h800000000000, sub: 1'b1, o5: 1'b0, cep: 1'b1, ceci: 1'b0};
        tbl[2] = '{x: ONES,             z: ONES,             sub: 1'b0, o5: 1'b1, cep: 1'b0, ceci: 1'b1};
        tbl[3] = '{x: 48'h000000000000, z: 48'h000000000000, sub: 1'b1, o5: 1'b0, cep: 1'b1, ceci: 1'b1};
        tbl[4] = '{x: 48'hAAAAAAAAAAAA, z: 48'h555555555555, sub: 1'b0, o5: 1'b0, cep: 1'b1, ceci: 1'b1};
        tbl[5] = '{x: 48'h000000000007, z: 48'h000000000007, sub: 1'b1, o5: 1'b0, cep: 1'b1, ceci: 1'b0};

        a_if.x = ONES; a_zdrv = ONES; a_if.opmode7 = 1'b0; a_if.opmode5 = 1'b1;
        a_if.CEP = 1'b1; a_if.CECARRYIN = 1'b1; a_if.CARRYIN = 1'b0;
        b_if.x = ONES; b_if.z = ONES; b_if.opmode7 = 1'b0; b_if.opmode5 = 1'b0;
        b_if.CEP = 1'b1; b_if.CECARRYIN = 1'b1; b_if.CARRYIN = 1'b1;
        rst = 1'b1;

        // Reset with all-ones operands and enables high.
        tick();
        check("rst_p",        64'(a_if.P),        64'h0);
        check("rst_pcout",    64'(a_if.PCOUT),    64'h0);
        check("rst_carryout", 64'(a_if.CARRYOUT), 64'h0);
        check("rst_cyi",      64'(a_if.cyi),      64'h0);
        check("rst_b_cyi",    64'(b_if.cyi),      64'h0);
        rst = 1'b0;

        op_a(48'h5, 48'h3, 1'b0, 1'b1);
        check("add_cin_p",  64'(a_if.P),        64'h9);
        check("add_cin_co", 64'(a_if.CARRYOUT), 64'h0);

        op_a(ONES, 48'h1, 1'b0, 1'b0);
        check("add_ovf_p",  64'(a_if.P),        64'h0);
        check("add_ovf_co", 64'(a_if.CARRYOUT), 64'h1);

        op_a(48'h3, 48'h2, 1'b1, 1'b0);
        check("sub_borrow_p",  64'(a_if.P),        64'(ONES));
        check("sub_borrow_co", 64'(a_if.CARRYOUT), 64'h1);

        op_a(48'h3, 48'h5, 1'b1, 1'b0);
        check("sub_p",  64'(a_if.P),        64'h2);
        check("sub_co", 64'(a_if.CARRYOUT), 64'h0);

        op_a(ONES, 48'h0, 1'b1, 1'b1);
        check("sub_wide_p",  64'(a_if.P),        64'h0);
        check("sub_wide_co", 64'(a_if.CARRYOUT), 64'h1);

        // Accumulate through P feedback, hold, then reset mid-accumulation.
        a_if.x = 48'd10; a_if.opmode7 = 1'b0; a_if.opmode5 = 1'b0;
        a_fb = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("acc_p", 64'(a_if.P), 64'(10 * i));
        end
        a_if.CEP = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("acc_hold_p", 64'(a_if.P), 64'd40);
        end
        a_if.CEP = 1'b1; rst = 1'b1;
        tick();
        check("acc_rst_p", 64'(a_if.P), 64'd0);
        rst = 1'b0;
        tick();
        check("acc_restart_p", 64'(a_if.P), 64'd10);
        a_fb = 1'b0;

        // Mixed enables; checked by the model only.
        foreach (tbl[i]) begin
            a_if.x = tbl[i].x; a_zdrv = tbl[i].z; a_if.opmode7 = tbl[i].sub;
            a_if.opmode5 = tbl[i].o5; a_if.CEP = tbl[i].cep; a_if.CECARRYIN = tbl[i].ceci;
            tick();
        end
        a_if.CEP = 1'b1; a_if.CECARRYIN = 1'b1;

        // Registered CARRYIN pipeline on the second slice.
        b_if.opmode7 = 1'b0; b_if.opmode5 = 1'b1;
        pulse_b(1'b1);
        check("cin_pipe_p", 64'(b_if.P), 64'd3);
        pulse_b(1'b0);
        check("cin_hold_p", 64'(b_if.P), 64'd2);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
